gpio_ctrl: RTL
==============

// Module: gpio_ctrl
// PURPOSE
//   Parametrised memory-mapped GPIO controller; successor to the single-register LED GPIO.
//   Adds per-pin direction, synchronised input readback, atomic set/clear and per-pin
//   edge interrupts. Sits on the CPU's simple select/write-enable peripheral bus.
// PARAMETERS
//   WIDTH        8   number of GPIO pins (1..32)
//   SYNC_STAGES  2   input synchroniser depth (>=2)
// PORTS
//   clk        in   1      system clock
//   reset      in   1      asynchronous, active-high reset
//   i_sel      in   1      chip select
//   i_we       in   1      write enable (qualified by i_sel)
//   i_addr     in   3      word register index
//   i_wdata    in   32     write data from CPU
//   o_rdata    out  32     read data to CPU (combinational from i_addr)
//   i_gpio_in  in   WIDTH  asynchronous pin inputs
//   o_gpio_out out  WIDTH  pin output values
//   o_gpio_oe  out  WIDTH  pin output enables (1 = drive)
//   o_irq      out  1      level interrupt request
// BEHAVIOUR
//   - Reset is async; all registers, synchroniser flops and edge history clear to 0.
//     o_gpio_out, o_gpio_oe, o_irq and the registers read back by o_rdata are 0 out of reset.
//   - Register map (i_addr): 0 OUT rw | 1 DIR rw | 2 IN ro | 3 IRQ_EN rw | 4 IRQ_STAT w1c |
//     5 IRQ_POL rw (0 rise, 1 fall) | 6 SET wo (OUT |= d) | 7 CLR wo (OUT &= ~d).
//   - Writes take effect on the clk edge where i_sel&&i_we; only i_wdata[WIDTH-1:0] is used.
//   - Reads: zero-extended to 32 bits; SET/CLR and the RO/WO mismatch cases read 0; no wait states.
//   - Writes to IN are ignored.
//   - o_gpio_out = OUT, o_gpio_oe = DIR. Both are registered; an output changes 1 cycle after the write.
//   - IN = last synchroniser stage; a pin change is visible in IN after SYNC_STAGES clk edges.
//   - Edge detect: prev <= IN each cycle. rise = IN&~prev, fall = ~IN&prev;
//     evt = POL ? fall : rise. IRQ_STAT |= evt one edge after IN changes.
//   - Simultaneous events: an evt bit set in the same cycle as a W1C of that bit -> set wins.
//   - IRQ_STAT latches regardless of IRQ_EN.
//   - o_irq = |(IRQ_STAT & IRQ_EN), combinational from registers.
//   - Changing POL does not create an event by itself (the event is based only on IN transitions).
//   - Reset mid-operation returns everything to the reset state immediately; pending events are lost.
// CONFIGURATION
//   GPIO_IRQ_EN defined: edge detect, IRQ_EN/IRQ_STAT/IRQ_POL and o_irq implemented as above.
//   GPIO_IRQ_EN undefined: no edge logic and no IRQ registers. Addresses 3-5 read 0 and ignore
//   writes; o_irq is tied 0. The OUT/DIR/IN/SET/CLR behaviour is unchanged.
// STRUCTURE
//   gpio_pkg: register index localparams (GPIO_REG_OUT..GPIO_REG_CLR), the address width (3),
//   and the bus data width (32).
//   Sub-module gpio_sync: WIDTH-wide, SYNC_STAGES-deep async-reset synchroniser,
//   instantiated once for i_gpio_in.
// TESTING
//   1 Reset: assert reset mid-traffic -> outputs, o_irq and all reads = 0 with no clk edge needed.
//   2 Write OUT=0xA5, DIR=0x0F -> o_gpio_out=0xA5, o_gpio_oe=0x0F next cycle; reads return the same.
//   3 SET 0x10 then CLR 0x05 on OUT=0xA5 -> OUT=0xB5, then 0xB0; SET/CLR read 0.
//   4 Drive i_gpio_in=0x3C -> IN reads 0x3C after exactly SYNC_STAGES edges, not earlier.
//   5 IRQ_EN=0x01, POL=0, pin0 0->1 -> IRQ_STAT=0x01, o_irq=1; W1C 0x01 -> o_irq=0;
//     W1C in the same cycle as a new edge -> bit stays 1.
//   6 Build without GPIO_IRQ_EN: toggle pins with all IRQ bits written 1 -> o_irq stays 0,
//     addresses 3-5 read 0.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO controller: register indices and bus widths.
package gpio_pkg;

    localparam int unsigned GPIO_ADDR_W = 3;
    localparam int unsigned GPIO_DATA_W = 32;

    localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_OUT      = 3'd0;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_DIR      = 3'd1;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_IN       = 3'd2;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_IRQ_EN   = 3'd3;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_IRQ_STAT = 3'd4;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_IRQ_POL  = 3'd5;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_SET      = 3'd6;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_REG_CLR      = 3'd7;

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage flop synchroniser bringing asynchronous pin levels into the clk domain.
module gpio_sync
    import gpio_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pins,
    output logic [WIDTH-1:0] synced
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= pins;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign synced = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO controller: OUT/DIR/IN, atomic SET/CLR and optional edge interrupts.
// Define GPIO_IRQ_EN to build the edge-detect and IRQ_EN/IRQ_STAT/IRQ_POL logic.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_sel,
    input  logic                   i_we,
    input  logic [GPIO_ADDR_W-1:0] i_addr,
    input  logic [GPIO_DATA_W-1:0] i_wdata,
    output logic [GPIO_DATA_W-1:0] o_rdata,
    input  logic [WIDTH-1:0]       i_gpio_in,
    output logic [WIDTH-1:0]       o_gpio_out,
    output logic [WIDTH-1:0]       o_gpio_oe,
    output logic                   o_irq
);

    logic             wr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] in_sync;
    logic             unused_wdata;

    assign wr    = i_sel & i_we;
    assign wdata = i_wdata[WIDTH-1:0];
    // Bits above WIDTH are deliberately ignored.
    assign unused_wdata = ^i_wdata;

    gpio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .pins   (i_gpio_in),
        .synced (in_sync)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= '0;
            dir_q <= '0;
        end else if (wr) begin
            case (i_addr)
                GPIO_REG_OUT: out_q <= wdata;
                GPIO_REG_DIR: dir_q <= wdata;
                GPIO_REG_SET: out_q <= out_q | wdata;
                GPIO_REG_CLR: out_q <= out_q & ~wdata;
                default: ;
            endcase
        end
    end

    assign o_gpio_out = out_q;
    assign o_gpio_oe  = dir_q;

`ifdef GPIO_IRQ_EN
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] en_q;
    logic [WIDTH-1:0] pol_q;
    logic [WIDTH-1:0] stat_q;
    logic [WIDTH-1:0] stat_d;
    logic [WIDTH-1:0] evt;

    assign evt = (pol_q & ~in_sync & prev_q) | (~pol_q & in_sync & ~prev_q);

    // New events are OR-ed in after the W1C so a coincident set wins.
    always_comb begin
        stat_d = stat_q;
        if (wr && (i_addr == GPIO_REG_IRQ_STAT)) begin
            stat_d = stat_q & ~wdata;
        end
        stat_d = stat_d | evt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
            en_q   <= '0;
            pol_q  <= '0;
            stat_q <= '0;
        end else begin
            prev_q <= in_sync;
            stat_q <= stat_d;
            if (wr && (i_addr == GPIO_REG_IRQ_EN)) begin
                en_q <= wdata;
            end
            if (wr && (i_addr == GPIO_REG_IRQ_POL)) begin
                pol_q <= wdata;
            end
        end
    end

    assign o_irq = |(stat_q & en_q);
`else
    assign o_irq = 1'b0;
`endif

    always_comb begin
        o_rdata = '0;
        case (i_addr)
            GPIO_REG_OUT:      o_rdata[WIDTH-1:0] = out_q;
            GPIO_REG_DIR:      o_rdata[WIDTH-1:0] = dir_q;
            GPIO_REG_IN:       o_rdata[WIDTH-1:0] = in_sync;
`ifdef GPIO_IRQ_EN
            GPIO_REG_IRQ_EN:   o_rdata[WIDTH-1:0] = en_q;
            GPIO_REG_IRQ_STAT: o_rdata[WIDTH-1:0] = stat_q;
            GPIO_REG_IRQ_POL:  o_rdata[WIDTH-1:0] = pol_q;
`endif
            default: ;
        endcase
    end

endmodule
